capture_ctrl: RTL and testbench



---
 rtl/capture_pkg.sv | 24 ++
 rtl/sample_tick_gen.sv | 28 ++
 rtl/capture_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_capture_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and default widths for the capture front end.
// Optional build macro used by capture_ctrl: CAPTURE_TEST_PATTERN_EN.
package capture_pkg;

    localparam int CAP_DW        = 16;
    localparam int CAP_CW        = 32;
    localparam int CAP_DIVW      = 24;
    localparam int CAP_DONE_HOLD = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRE    = 3'd1,
        ST_ARMED  = 3'd2,
        ST_POST   = 3'd3,
        ST_STREAM = 3'd4,
        ST_DONE   = 3'd5
    } cap_state_t;

    // States in which the divider runs and samples are emitted.
    function automatic logic is_run_state(input cap_state_t s);
        return (s == ST_PRE) || (s == ST_ARMED) || (s == ST_POST) || (s == ST_STREAM);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: down-counter that ticks when it reaches zero and then
// reloads with the period-minus-one value; cleared so a run starts with a tick.
module sample_tick_gen #(
    parameter int DIVW = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            enable,
    input  logic [DIVW-1:0] reload,
    output logic            tick
);

    logic [DIVW-1:0] cnt;

    assign tick = enable && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? reload : cnt - DIVW'(1);
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: divides core_clk into sample ticks, registers the probe bus and
// runs pre/armed/post/stream sequencing. Build macro: CAPTURE_TEST_PATTERN_EN.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int DW        = CAP_DW,
    parameter int CW        = CAP_CW,
    parameter int DIVW      = CAP_DIVW,
    parameter int DONE_HOLD = CAP_DONE_HOLD
) (
    input  logic            core_clk,
    input  logic            core_rst,
    input  logic            sample_en,
    input  logic            cons_mode,
    input  logic [DIVW-1:0] sample_divider,
    input  logic [CW-1:0]   sample_depth,
    input  logic [CW-1:0]   trig_pos,
    input  logic            trig_hit,
    input  logic [DW-1:0]   probe_data,
    input  logic            wfifo_full,
    output logic            capture_valid,
    output logic [DW-1:0]   capture_data,
    output logic            capture_done,
    output logic [CW-1:0]   sample_last_cnt,
    output logic [CW-1:0]   trig_loc,
    output logic            overflow,
    output logic [2:0]      dbg_state
);

    localparam int            HW        = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((DONE_HOLD > 0) ? DONE_HOLD - 1 : 0);

    cap_state_t      state;
    logic            en_q;
    logic            cons_lat;
    logic            arm;
    logic            tick;
    logic            tick_en;
    logic [DIVW-1:0] div_lat;
    logic [CW-1:0]   depth_lat;
    logic [CW-1:0]   trig_lat;
    logic [CW-1:0]   trig_clamp;
    logic [CW-1:0]   pre_cnt;
    logic [CW-1:0]   post_left;
    logic [CW-1:0]   ring_idx;
    logic [CW-1:0]   ring_next;
    logic [HW-1:0]   hold_cnt;
    logic [DW-1:0]   sample_word;

    assign arm        = (state == ST_IDLE) && sample_en && !en_q;
    assign tick_en    = is_run_state(state) && sample_en;
    assign trig_clamp = (trig_pos >= sample_depth) ? sample_depth - CW'(1) : trig_pos;
    // ring_idx is the buffer slot the next emitted sample will occupy.
    assign ring_next  = (ring_idx == sample_last_cnt) ? '0 : ring_idx + CW'(1);
    assign dbg_state  = state;

    sample_tick_gen #(
        .DIVW(DIVW)
    ) u_tick (
        .clk    (core_clk),
        .rst    (core_rst),
        .clear  (arm),
        .enable (tick_en),
        .reload (div_lat),
        .tick   (tick)
    );

`ifdef CAPTURE_TEST_PATTERN_EN
    logic [DW-1:0] pattern;

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            pattern <= '0;
        end else if (arm) begin
            pattern <= '0;
        end else if (tick) begin
            pattern <= pattern + DW'(1);
        end
    end

    assign sample_word = pattern;
`else
    assign sample_word = probe_data;
`endif

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state           <= ST_IDLE;
            en_q            <= 1'b0;
            cons_lat        <= 1'b0;
            div_lat         <= '0;
            depth_lat       <= '0;
            trig_lat        <= '0;
            pre_cnt         <= '0;
            post_left       <= '0;
            ring_idx        <= '0;
            hold_cnt        <= '0;
            capture_valid   <= 1'b0;
            capture_data    <= '0;
            capture_done    <= 1'b0;
            sample_last_cnt <= '0;
            trig_loc        <= '0;
            overflow        <= 1'b0;
        end else begin
            en_q          <= sample_en;
            capture_valid <= tick;
            if (tick) begin
                capture_data <= sample_word;
                ring_idx     <= ring_next;
            end
            // Samples are never stalled; a full write FIFO only leaves a sticky mark.
            if (capture_valid && wfifo_full) begin
                overflow <= 1'b1;
            end
            if (state != ST_DONE) begin
                hold_cnt <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        cons_lat        <= cons_mode;
                        div_lat         <= sample_divider;
                        depth_lat       <= sample_depth;
                        trig_lat        <= trig_clamp;
                        sample_last_cnt <= sample_depth - CW'(1);
                        pre_cnt         <= '0;
                        ring_idx        <= '0;
                        trig_loc        <= '0;
                        overflow        <= 1'b0;
                        if (sample_depth == '0) begin
                            state        <= ST_DONE;
                            capture_done <= 1'b1;
                        end else if (trig_clamp == '0) begin
                            state <= cons_mode ? ST_STREAM : ST_ARMED;
                        end else begin
                            state <= ST_PRE;
                        end
                    end
                end

                ST_PRE: begin
                    if (!sample_en) begin
                        state        <= ST_DONE;
                        capture_done <= 1'b1;
                    end else if (tick) begin
                        pre_cnt <= pre_cnt + CW'(1);
                        // The tick completing the pre-trigger count never acts as a trigger.
                        if (pre_cnt + CW'(1) == trig_lat) begin
                            state <= cons_lat ? ST_STREAM : ST_ARMED;
                        end
                    end
                end

                ST_ARMED: begin
                    if (!sample_en) begin
                        state        <= ST_DONE;
                        capture_done <= 1'b1;
                    end else if (tick && trig_hit) begin
                        trig_loc  <= ring_idx;
                        post_left <= depth_lat - trig_lat - CW'(1);
                        if (depth_lat - trig_lat == CW'(1)) begin
                            state        <= ST_DONE;
                            capture_done <= 1'b1;
                        end else begin
                            state <= ST_POST;
                        end
                    end
                end

                ST_POST: begin
                    if (!sample_en) begin
                        state        <= ST_DONE;
                        capture_done <= 1'b1;
                    end else if (tick) begin
                        post_left <= post_left - CW'(1);
                        if (post_left == CW'(1)) begin
                            state        <= ST_DONE;
                            capture_done <= 1'b1;
                        end
                    end
                end

                ST_STREAM: begin
                    if (!sample_en) begin
                        state        <= ST_DONE;
                        capture_done <= 1'b1;
                    end
                end

                ST_DONE: begin
                    if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end else if (!sample_en) begin
                        state        <= ST_IDLE;
                        capture_done <= 1'b0;
                    end
                end

                default: begin
                    state        <= ST_IDLE;
                    capture_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: scenario tasks plus a sample scoreboard
// fed by the stimulus driver and drained when capture_valid is observed.
module tb_capture_ctrl;

    localparam int DW   = 16;
    localparam int CW   = 32;
    localparam int DIVW = 24;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRE    = 3'd1;
    localparam logic [2:0] S_ARMED  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int NEVER = 1000;

    logic            clk;
    logic            rst;
    logic            sample_en;
    logic            cons_mode;
    logic [DIVW-1:0] sample_divider;
    logic [CW-1:0]   sample_depth;
    logic [CW-1:0]   trig_pos;
    logic            trig_hit;
    logic [DW-1:0]   probe_data;
    logic            wfifo_full;
    logic            capture_valid;
    logic [DW-1:0]   capture_data;
    logic            capture_done;
    logic [CW-1:0]   sample_last_cnt;
    logic [CW-1:0]   trig_loc;
    logic            overflow;
    logic [2:0]      dbg_state;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;
    int            checks   = 0;
    int            failures = 0;
    int            n_valid  = 0;

    capture_ctrl #(
        .DW(DW), .CW(CW), .DIVW(DIVW), .DONE_HOLD(4)
    ) dut (
        .core_clk        (clk),
        .core_rst        (rst),
        .sample_en       (sample_en),
        .cons_mode       (cons_mode),
        .sample_divider  (sample_divider),
        .sample_depth    (sample_depth),
        .trig_pos        (trig_pos),
        .trig_hit        (trig_hit),
        .probe_data      (probe_data),
        .wfifo_full      (wfifo_full),
        .capture_valid   (capture_valid),
        .capture_data    (capture_data),
        .capture_done    (capture_done),
        .sample_last_cnt (sample_last_cnt),
        .trig_loc        (trig_loc),
        .overflow        (overflow),
        .dbg_state       (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // scoreboard: drain one expected sample per observed strobe
    always @(negedge clk) begin
        if (!rst && capture_valid) begin
            n_valid++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_sample: got data %h with no sample expected", capture_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (capture_data !== exp_v) begin
                    failures++;
                    $display("FAIL sample_data: got %h expected %h", capture_data, exp_v);
                end
            end
        end
    end

    // driver tasks
    task automatic arm(input int div, input int depth, input int tp, input logic cons);
        sample_divider = DIVW'(div);
        sample_depth   = CW'(depth);
        trig_pos       = CW'(tp);
        cons_mode      = cons;
        n_valid        = 0;
        sample_en      = 1'b1;
        @(posedge clk); #1;
    endtask

    // Drives n_cyc cycles of random probe data; every (div+1)-th cycle is a tick
    // whose probe value is pushed as the next expected sample (up to n_samp).
    task automatic run(input int div, input int n_samp, input int n_cyc,
                       input int trig_at, input int full_at);
        int          sidx;
        logic [DW-1:0] p;
        sidx = 0;
        for (int c = 0; c < n_cyc; c++) begin
            p          = DW'($urandom);
            probe_data = p;
            wfifo_full = (c == full_at);
            trig_hit   = 1'b0;
            if ((c % (div + 1)) == 0 && sidx < n_samp) begin
                exp_q.push_back(p);
                trig_hit = (trig_at == -1) || (sidx == trig_at);
                sidx++;
            end
            @(posedge clk); #1;
        end
        trig_hit   = 1'b0;
        wfifo_full = 1'b0;
    endtask

    task automatic finish_run();
        int waited;
        waited    = 0;
        sample_en = 1'b0;
        while (dbg_state !== S_IDLE && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (dbg_state !== S_IDLE) begin
            failures++;
            $display("FAIL return_idle: state %0d expected %0d after %0d cycles", dbg_state, S_IDLE, waited);
        end
        checks++;
        if (capture_done !== 1'b0) begin
            failures++;
            $display("FAIL done_clear: capture_done %0b expected 0", capture_done);
        end
    endtask

    // scenarios
    task automatic test_reset();
        rst            = 1'b1;
        sample_en      = 1'b0;
        cons_mode      = 1'b0;
        sample_divider = '0;
        sample_depth   = '0;
        trig_pos       = '0;
        trig_hit       = 1'b0;
        probe_data     = '0;
        wfifo_full     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({capture_valid, capture_data, capture_done, sample_last_cnt, trig_loc, overflow, dbg_state} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid %0b data %h done %0b last %0d loc %0d ovf %0b state %0d expected all 0",
                     capture_valid, capture_data, capture_done, sample_last_cnt, trig_loc, overflow, dbg_state);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dbg_state !== S_IDLE || capture_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: state %0d valid %0b expected %0d 0", dbg_state, capture_valid, S_IDLE);
        end
    endtask

    task automatic test_trigger_basic();
        int done_cnt;
        arm(0, 8, 2, 1'b0);
        checks++;
        if (dbg_state !== S_PRE) begin
            failures++;
            $display("FAIL enter_pre: state %0d expected %0d", dbg_state, S_PRE);
        end
        run(0, 10, 10, 4, -1);
        checks++;
        if (capture_done !== 1'b1) begin
            failures++;
            $display("FAIL done_after_post: capture_done %0b expected 1", capture_done);
        end
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (capture_done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 6) begin
            failures++;
            $display("FAIL done_hold_en_high: %0d cycles high expected 6", done_cnt);
        end
        checks++;
        if (n_valid != 10 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_count: got %0d samples (%0d pending) expected 10", n_valid, exp_q.size());
        end
        checks++;
        if (trig_loc !== 32'd4) begin
            failures++;
            $display("FAIL basic_trig_loc: got %0d expected 4", trig_loc);
        end
        checks++;
        if (sample_last_cnt !== 32'd7) begin
            failures++;
            $display("FAIL basic_last_cnt: got %0d expected 7", sample_last_cnt);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL basic_overflow: got %0b expected 0", overflow);
        end
        finish_run();
    endtask

    task automatic test_divider();
        arm(3, 4, 0, 1'b0);
        checks++;
        if (dbg_state !== S_ARMED) begin
            failures++;
            $display("FAIL direct_armed: state %0d expected %0d", dbg_state, S_ARMED);
        end
        run(3, 4, 16, -1, -1);
        checks++;
        if (n_valid != 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL div_count: got %0d samples (%0d pending) expected 4", n_valid, exp_q.size());
        end
        checks++;
        if (trig_loc !== 32'd0 || sample_last_cnt !== 32'd3) begin
            failures++;
            $display("FAIL div_loc_last: loc %0d last %0d expected 0 3", trig_loc, sample_last_cnt);
        end
        checks++;
        if (dbg_state !== S_DONE) begin
            failures++;
            $display("FAIL div_done: state %0d expected %0d", dbg_state, S_DONE);
        end
        finish_run();
    endtask

    task automatic test_ring_wrap();
        arm(1, 4, 2, 1'b0);
        run(1, 11, 22, 9, 2);
        checks++;
        if (n_valid != 11 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_count: got %0d samples (%0d pending) expected 11", n_valid, exp_q.size());
        end
        checks++;
        if (trig_loc !== 32'd1) begin
            failures++;
            $display("FAIL wrap_trig_loc: got %0d expected 1", trig_loc);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_without_valid: overflow %0b expected 0", overflow);
        end
        finish_run();
    endtask

    task automatic test_abort();
        int done_cnt;
        arm(0, 8, 2, 1'b0);
        run(0, 4, 4, NEVER, -1);
        sample_en = 1'b0;
        done_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                checks++;
                if (dbg_state !== S_DONE || capture_done !== 1'b1) begin
                    failures++;
                    $display("FAIL abort_next_cycle: state %0d done %0b expected %0d 1", dbg_state, capture_done, S_DONE);
                end
            end
            if (capture_done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 4) begin
            failures++;
            $display("FAIL abort_done_hold: %0d cycles high expected 4", done_cnt);
        end
        checks++;
        if (n_valid != 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_inflight: got %0d samples (%0d pending) expected 4", n_valid, exp_q.size());
        end
        checks++;
        if (dbg_state !== S_IDLE) begin
            failures++;
            $display("FAIL abort_idle: state %0d expected %0d", dbg_state, S_IDLE);
        end
    endtask

    task automatic test_stream();
        arm(1, 4, 0, 1'b1);
        checks++;
        if (dbg_state !== S_STREAM) begin
            failures++;
            $display("FAIL enter_stream: state %0d expected %0d", dbg_state, S_STREAM);
        end
        run(1, 6, 12, NEVER, 3);
        finish_run();
        checks++;
        if (n_valid != 6 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stream_count: got %0d samples (%0d pending) expected 6", n_valid, exp_q.size());
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set: got %0b expected 1", overflow);
        end
        checks++;
        if (trig_loc !== 32'd0) begin
            failures++;
            $display("FAIL stream_trig_loc: got %0d expected 0", trig_loc);
        end
        arm(0, 0, 0, 1'b0);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_rearm: got %0b expected 0", overflow);
        end
        finish_run();
    endtask

    task automatic test_boundaries();
        arm(0, 0, 5, 1'b0);
        checks++;
        if (dbg_state !== S_DONE || capture_done !== 1'b1) begin
            failures++;
            $display("FAIL depth0_done: state %0d done %0b expected %0d 1", dbg_state, capture_done, S_DONE);
        end
        repeat (6) @(posedge clk);
        #1;
        finish_run();
        checks++;
        if (n_valid != 0) begin
            failures++;
            $display("FAIL depth0_samples: got %0d expected 0", n_valid);
        end
        arm(0, 4, 10, 1'b0);
        run(0, 4, 6, 3, -1);
        checks++;
        if (n_valid != 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL clamp_count: got %0d samples (%0d pending) expected 4", n_valid, exp_q.size());
        end
        checks++;
        if (trig_loc !== 32'd3 || sample_last_cnt !== 32'd3) begin
            failures++;
            $display("FAIL clamp_loc_last: loc %0d last %0d expected 3 3", trig_loc, sample_last_cnt);
        end
        checks++;
        if (dbg_state !== S_DONE) begin
            failures++;
            $display("FAIL clamp_done: state %0d expected %0d", dbg_state, S_DONE);
        end
        finish_run();
    endtask

    initial begin
        test_reset();
        test_trigger_basic();
        test_divider();
        test_ring_wrap();
        test_abort();
        test_stream();
        test_boundaries();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_queue: %0d samples pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
